data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: DEPTH_LOG2, 10, log2 of the number of 32-bit words stored.
REQ-002 Parameter: READ_LATENCY, 1, load access cycles, legal range 1..4.
REQ-003 Parameter: BASE_ADDR, 32'h0000_0000, byte address of word 0.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: resetn  input  1  reset, asynchronous and active-low.
REQ-006 Port: req_valid  input  1  request present.
REQ-007 Port: req_ready  output  1  block can accept a request.
REQ-008 Port: req_wr  input  1  1 = store, 0 = load.
REQ-009 Port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 Port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 Port: req_addr  input  32  byte address.
REQ-012 Port: req_wdata  input  32  store data, right-aligned.
REQ-013 Port: resp_valid  output  1  response present.
REQ-014 Port: resp_ready  input  1  consumer accepts response.
REQ-015 Port: resp_rdata  output  32  load result, right-aligned and extended.
REQ-016 Port: resp_err  output  1  request rejected; no memory side effect.

Function
REQ-017 The block SHALL hold 2^DEPTH_LOG2 words with byte-granular write lanes, little-endian, with lane = offset[1:0].
REQ-018 Definitions: offset = req_addr - BASE_ADDR, mod 2^32; word index = offset[DEPTH_LOG2+1:2].
REQ-019 States: IDLE, ACCESS, RESP. req_ready SHALL be 1 only in IDLE.
REQ-020 Acceptance SHALL occur when req_valid and req_ready are both 1; all request fields SHALL be latched at acceptance.
REQ-021 Error cases: size 11; halfword with offset[0]=1; word with offset[1:0]!=0; offset >= 4*2^DEPTH_LOG2.
REQ-022 Error response: IDLE->RESP directly; resp_valid in cycle 1 after acceptance (cycle 0); resp_err=1; resp_rdata=0; memory unchanged.
REQ-023 Load: IDLE->ACCESS for READ_LATENCY cycles, then RESP; resp_valid rises in cycle READ_LATENCY+1.
REQ-024 Load data: selected byte/halfword/word SHALL be right-aligned, then zero- or sign-extended per req_unsigned; word loads ignore req_unsigned.
REQ-025 Store: IDLE->ACCESS for exactly 1 cycle regardless of READ_LATENCY; write lanes commit on the edge leaving ACCESS; resp_valid rises in cycle 2.
REQ-026 Store lane data: byte = req_wdata[7:0] at lane offset[1:0]; halfword = req_wdata[15:0] at lanes offset[1]*2+{0,1}; word = all lanes. Untouched lanes SHALL be preserved.
REQ-027 Store response: resp_rdata=0, resp_err=0.
REQ-028 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1; that edge returns to IDLE.
REQ-029 A new request SHALL NOT be accepted in the same cycle as the response handshake; minimum request spacing is 3 cycles for stores and READ_LATENCY+2 for loads.
REQ-030 req_* inputs outside the acceptance cycle SHALL have no effect.
REQ-031 A load following a store to the same word SHALL return the stored data.

Reset
REQ-032 While resetn=0: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0; req_ready SHALL become 1 in the first cycle after deassertion.
REQ-033 Reset during ACCESS SHALL abort the operation. A store not yet committed SHALL NOT write. A pending response SHALL be discarded.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 Store word 32'hDEADBEEF at 0x10, then load word 0x10 with READ_LATENCY=1 -> store resp_valid in cycle 2 with rdata=0 and err=0; load resp_valid in cycle 2 with rdata=32'hDEADBEEF.
REQ-036 After REQ-035: store byte 8'h80 at 0x13; load signed byte at 0x13 -> 32'hFFFFFF80; load unsigned byte -> 32'h00000080; load word 0x10 -> 32'h80ADBEEF.
REQ-037 Load halfword at 0x11 -> resp_err=1 in cycle 1 and memory unchanged. Store word at 0x1000 with DEPTH_LOG2=10 -> resp_err=1 and no write. req_size=11 -> resp_err=1.
REQ-038 READ_LATENCY=3: load accepted in cycle 0 -> resp_valid in cycle 4; hold resp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout; response completes on the first cycle with resp_ready=1.
REQ-039 Pull resetn low in the ACCESS cycle of a store of 32'h12345678 to 0x20 (prior content 0) -> resp_valid=0 immediately; after release, load 0x20 returns 32'h00000000.
REQ-040 BASE_ADDR=32'h1000_0000: load at 32'h0FFF_FFFC -> resp_err=1; store and load at 32'h1000_0FFC -> data round-trips.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store client and data_mem_ctrl.
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with byte/halfword/word loads and stores,
// one outstanding request at a time, programmable load latency.
module data_mem_ctrl #(
    parameter int          DEPTH_LOG2   = 10,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           resetn,
    data_mem_ctrl_if.slave bus
);
    localparam int         WORDS    = 1 << DEPTH_LOG2;
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic [31:0]             mem [WORDS];
    logic [31:0]             off;
    logic                    bad;
    logic                    accept;
    logic                    wr_q, uns_q;
    logic [1:0]              size_q;
    logic [DEPTH_LOG2+1:0]   off_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic [1:0]              lat_cnt;
    logic [31:0]             rdata_q;
    logic                    err_q;
    logic [31:0]             rword, rsh, load_data;
    logic [3:0]              be;
    logic [31:0]             wlanes;

    assign off    = bus.req_addr - BASE_ADDR;
    assign idx_q  = off_q[DEPTH_LOG2+1:2];
    // req_ready is forced low while reset is held, not only after the next edge
    assign bus.req_ready  = (state == IDLE) && resetn;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    // Classify the incoming request: bad size, misalignment, or out of range
    always_comb begin
        bad = 1'b0;
        case (bus.req_size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = |off[1:0];
            default: bad = 1'b1;
        endcase
        if (|off[31:DEPTH_LOG2+2]) bad = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state: errors skip ACCESS, stores spend one cycle there, loads READ_LATENCY
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bad ? RESP : ACCESS;
            ACCESS:  if (wr_q || lat_cnt == LAT_LAST) state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load path: pick the addressed lanes, right-align, then extend
    always_comb begin
        rword = mem[idx_q];
        rsh   = rword >> {off_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_data = uns_q ? {24'd0, rsh[7:0]}  : {{24{rsh[7]}}, rsh[7:0]};
            2'b01:   load_data = uns_q ? {16'd0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
            default: load_data = rword;
        endcase
    end

    // Store path: replicate data across lanes and enable only the addressed ones
    always_comb begin
        case (size_q)
            2'b00:   begin be = 4'b0001 << off_q[1:0];            wlanes = {4{wdata_q[7:0]}};  end
            2'b01:   begin be = off_q[1] ? 4'b1100 : 4'b0011;     wlanes = {2{wdata_q[15:0]}}; end
            default: begin be = 4'b1111;                          wlanes = wdata_q;            end
        endcase
    end

    // Request latch, latency count and response registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= '0;
            wdata_q <= '0;
            lat_cnt <= 2'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_wr;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                off_q   <= off[DEPTH_LOG2+1:0];
                wdata_q <= bus.req_wdata;
                lat_cnt <= 2'd0;
                rdata_q <= '0;
                err_q   <= bad;
            end
            if (state == ACCESS) begin
                lat_cnt <= lat_cnt + 2'd1;
                if (!wr_q && state_nxt == RESP) rdata_q <= load_data;
            end
            if (state == RESP && bus.resp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Memory array is never cleared; a reset in ACCESS drops state to IDLE first,
    // so an uncommitted store never reaches this edge
    always_ff @(posedge clk) begin
        if (state == ACCESS && wr_q) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx_q][8*b +: 8] <= wlanes[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (latency 1 / base 0, latency 3 / base 0x1000_0000)
// driven through one muxed request port, checked against a byte-array model.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    data_mem_ctrl_if b0 ();
    data_mem_ctrl_if b1 ();

    assign b0.req_valid = req_valid && !sel;   assign b1.req_valid = req_valid && sel;
    assign b0.resp_ready = resp_ready && !sel; assign b1.resp_ready = resp_ready && sel;
    assign b0.req_wr = req_wr;                 assign b1.req_wr = req_wr;
    assign b0.req_size = req_size;             assign b1.req_size = req_size;
    assign b0.req_unsigned = req_unsigned;     assign b1.req_unsigned = req_unsigned;
    assign b0.req_addr = req_addr;             assign b1.req_addr = req_addr;
    assign b0.req_wdata = req_wdata;           assign b1.req_wdata = req_wdata;
    assign req_ready  = sel ? b1.req_ready  : b0.req_ready;
    assign resp_valid = sel ? b1.resp_valid : b0.resp_valid;
    assign resp_err   = sel ? b1.resp_err   : b0.resp_err;
    assign resp_rdata = sel ? b1.resp_rdata : b0.resp_rdata;

    data_mem_ctrl #(.DEPTH_LOG2(10), .READ_LATENCY(1), .BASE_ADDR(32'h0000_0000))
        dut0 (.clk(clk), .resetn(resetn), .bus(b0));
    data_mem_ctrl #(.DEPTH_LOG2(10), .READ_LATENCY(3), .BASE_ADDR(32'h1000_0000))
        dut1 (.clk(clk), .resetn(resetn), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory per instance
    logic [7:0] mm [2][4096];

    function automatic logic [31:0] base_of(input bit s);
        return s ? 32'h1000_0000 : 32'h0000_0000;
    endfunction

    task automatic model(input bit s, input bit wr, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output bit e, output int lat);
        logic [31:0] offs;
        int n;
        offs = addr - base_of(s);
        n = 1 << size;
        rd = '0;
        e = (size == 2'b11) || (offs % n != 0) || (offs >= 32'd4096);
        if (e) lat = 1;
        else if (wr) begin
            for (int i = 0; i < n; i++) mm[s][offs + i] = wdata[8*i +: 8];
            lat = 2;
        end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = mm[s][offs + i];
            if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
            lat = (s ? 3 : 1) + 1;
        end
    endtask

    // Drive one request, measure response latency, hold the response, then complete it
    task automatic run_txn(input string name, input bit s, input bit wr, input logic [1:0] size,
                           input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                           input int hold);
        int g, cyc;
        bit stable;
        logic [31:0] cap_rd;
        logic cap_err;
        sel = s;
        #0;
        g = 0;
        while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_wr = wr; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // garbage on the request fields after acceptance must be ignored
        req_wr = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        cyc = 1;
        while (!resp_valid && cyc < 12) begin @(posedge clk); #1; cyc++; end
        check({name, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({name, "_rdata"}, resp_rdata, exp_rd);
        check({name, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        cap_rd = resp_rdata; cap_err = resp_err; stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!resp_valid || resp_rdata !== cap_rd || resp_err !== cap_err || req_ready) stable = 1'b0;
        end
        if (hold > 0) check({name, "_hold"}, {31'd0, stable}, 32'd1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({name, "_done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    typedef struct {
        bit          s;
        bit          wr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          err;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit s, bit wr, logic [1:0] size, bit uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rd, bit err, int lat, int hold);
        vec_t v;
        v.s = s; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rd = rd; v.err = err; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit e;
        int lat;

        for (int s = 0; s < 2; s++) for (int i = 0; i < 4096; i++) mm[s][i] = 8'h00;

        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0));
        tbl.push_back(mk(0, 1, 2'b00, 0, 32'h13, 32'h80,       32'h0,        0, 2, 1));
        tbl.push_back(mk(0, 0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b00, 1, 32'h13, 32'h0,        32'h00000080, 0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h80ADBEEF, 0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b01, 0, 32'h11, 32'h0,        32'h0,        1, 1, 2));
        tbl.push_back(mk(0, 0, 2'b10, 1, 32'h10, 32'h0,        32'h80ADBEEF, 0, 2, 0));
        tbl.push_back(mk(0, 1, 2'b10, 0, 32'h1000, 32'h55AA55AA, 32'h0,      1, 1, 0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h0,  32'h0,        32'h0,        0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 1, 2'b01, 0, 32'h16, 32'h1234ABCD, 32'h0,        0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b10, 0, 32'h14, 32'h0,        32'hABCD0000, 0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b01, 0, 32'h16, 32'h0,        32'hFFFFABCD, 0, 2, 0));
        tbl.push_back(mk(0, 0, 2'b01, 1, 32'h16, 32'h0,        32'h0000ABCD, 0, 2, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h0FFFFFFC, 32'h0,  32'h0,        1, 1, 0));
        tbl.push_back(mk(1, 1, 2'b10, 0, 32'h10000FFC, 32'hCAFEF00D, 32'h0,  0, 2, 0));
        tbl.push_back(mk(1, 0, 2'b10, 0, 32'h10000FFC, 32'h0,  32'hCAFEF00D, 0, 4, 5));
        tbl.push_back(mk(1, 0, 2'b00, 0, 32'h10000FFE, 32'h0,  32'hFFFFFFFE, 0, 4, 0));

        // reset state of both instances
        #12;
        sel = 1'b0; #1;
        check("rst0_ready", {31'd0, req_ready}, 32'd0);
        check("rst0_valid", {31'd0, resp_valid}, 32'd0);
        check("rst0_err", {31'd0, resp_err}, 32'd0);
        check("rst0_rdata", resp_rdata, 32'd0);
        sel = 1'b1; #1;
        check("rst1_ready", {31'd0, req_ready}, 32'd0);
        check("rst1_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1; #1;
        check("rst1_ready_after", {31'd0, req_ready}, 32'd1);
        sel = 1'b0; #1;
        check("rst0_ready_after", {31'd0, req_ready}, 32'd1);

        // clear the low region of both memories so random loads read known data
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 64; w++)
                run_txn("fill", s[0], 1, 2'b10, 0, base_of(s[0]) + 32'(4*w), 32'h0, 32'h0, 0, 2, 0);

        // reset in the ACCESS cycle of a store: no write, no response
        sel = 1'b0;
        @(posedge clk); #1;
        check("rstacc_ready", {31'd0, req_ready}, 32'd1);
        req_wr = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        resetn = 1'b0; #1;
        check("rstacc_valid", {31'd0, resp_valid}, 32'd0);
        check("rstacc_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1; #1;
        check("rstacc_ready_back", {31'd0, req_ready}, 32'd1);
        run_txn("rstacc_load", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, 2, 0);

        // directed table
        foreach (tbl[i]) begin
            model(tbl[i].s, tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, e, lat);
            run_txn($sformatf("vec%0d", i), tbl[i].s, tbl[i].wr, tbl[i].size, tbl[i].uns,
                    tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err, tbl[i].lat, tbl[i].hold);
        end

        // randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            bit s, wr, uns;
            logic [1:0] size;
            logic [31:0] addr, wdata;
            s = 1'($urandom);
            wr = 1'($urandom);
            uns = 1'($urandom);
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = base_of(s) + 32'($urandom_range(0, 255));
            wdata = $urandom;
            model(s, wr, size, uns, addr, wdata, rd, e, lat);
            run_txn($sformatf("rnd%0d", k), s, wr, size, uns, addr, wdata, rd, e, lat,
                    $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
